seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

- Time-multiplexing controller for a 4-digit common-anode seven-segment display.
- Holds a 16-bit display word and steps a 2-bit digit select through digits 0..3.
- For each digit it routes the matching nibble to the shared hex decoder and drives the active-low anode enables, with a dead-time gap between digits to prevent ghosting.
- Sits between the value producer (load handshake) and the nibble mux / hex-to-7-segment decoder path.

## Interface
Parameters:
- PRESCALE, 50000: clock cycles per digit slot; legal range BLANK+2 .. 2^20.
- BLANK, 16: dead-time cycles at the start of each slot with all anodes off; minimum 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable; 0 blanks the display and parks the scan.
- value  in  16  new display word; nibble k drives digit k.
- load  in  1  request to adopt `value`.
- load_ack  out  1  one-cycle pulse when the pending word becomes the displayed word.
- nibble  out  4  nibble for the current digit, to the decoder.
- digit  out  2  current digit index, mux select.
- an  out  4  anode enables, active-low; bit k is digit k.
- frame  out  1  one-cycle pulse on the last cycle of digit 3's slot.

## Operation
- Registers:
  - slot counter `cnt` (0..PRESCALE-1)
  - `digit`
  - state: BLANK or SHOW
  - `disp_reg` (16 bits, displayed word)
  - `pend_reg` (16 bits) and `pending` flag
- Scan FSM (en=1):
  - BLANK: an=1111; when cnt==BLANK-1, go to SHOW.
  - SHOW: an = ~(1<<digit).
  - When cnt==PRESCALE-1: cnt←0, digit←digit+1 (3 wraps to 0), state←BLANK.
  - Otherwise cnt increments every cycle.
- nibble = disp_reg[4*digit+3 : 4*digit], registered; updates on the same edge as `digit`.
- Load handshake:
  - load=1 samples `value` into pend_reg and sets pending.
  - load=1 while pending is already set overwrites pend_reg; last value wins, and only one ack is issued.
- Commit point is the frame boundary: the edge where digit wraps 3→0. On that edge:
  - if pending, then disp_reg←pend_reg, pending←0, load_ack pulses on the following cycle;
  - if load=1 with pending clear, `value` goes straight to disp_reg and is acked.
- en=0:
  - cnt←0, digit←0, state←BLANK, an=1111, frame=0.
  - A pending word commits on the next edge (ack follows).
  - When en returns to 1, the scan restarts from digit 0 in BLANK.
- Width rules: cnt is $clog2(PRESCALE) bits; no arithmetic beyond the increment and wrap.

## Timing
- Reset values: an=1111, nibble=0, digit=0, load_ack=0, frame=0; disp_reg=0, pend_reg=0, pending=0, cnt=0, state BLANK.
- All outputs are registered. No combinational path from any input to any output.
- Per-slot timing: an stays 1111 for exactly BLANK cycles, then one anode is low for PRESCALE-BLANK cycles.
- Full frame = 4·PRESCALE cycles.
- frame is high during cycle cnt==PRESCALE-1 of digit 3.
- load_ack is high exactly one cycle, one cycle after the commit edge.
- Worst-case load→ack latency is 4·PRESCALE+1 cycles.
- Reset mid-slot: outputs return to reset values asynchronously and any pending word is discarded.

## Configuration
- Macro: SEG_LZ_BLANK_EN (leading-zero blanking).
- Defined:
  - In SHOW, the anode for digit k (k=3..1) stays off when disp_reg nibbles k..3 are all zero.
  - Digit 0 is always lit.
  - Slot timing, digit, nibble and frame are unchanged.
- Undefined: all four digits are lit in SHOW regardless of value.

## Test plan
Bench uses PRESCALE=8, BLANK=2.
- Reset, then en=1:
  - an=1111 for 2 cycles, then 1110 for 6, then 1111 for 2, then 1101 for 6.
  - digit steps 0,1,2,3,0; frame pulses every 32 cycles.
- Pulse load with value=16'h1A2F mid-frame → disp_reg is unchanged until the 3→0 wrap, load_ack pulses 1 cycle after; next frame nibble = F,2,A,1.
- Load 16'h1111 then 16'h2222 within one frame → a single load_ack; the displayed word is 16'h2222.
- Drop en to 0 mid-slot of digit 2:
  - next edge gives an=1111, digit=0;
  - a pending 16'h00AB commits within 1 cycle;
  - on re-enable the scan restarts at digit 0 with a 2-cycle BLANK.
- Assert rst mid-SHOW → an=1111 immediately; after release, nibble=0 and the pending flag is cleared (no load_ack).
- With SEG_LZ_BLANK_EN and value=16'h0005: only digit 0 anode goes low; with value=16'h0000, digit 0 still lights and shows nibble 0.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// Bundle between the value producer / display path and the seven-segment scan controller.
interface seg_scan_ctrl_if;
    logic        en;
    logic [15:0] value;
    logic        load;
    logic        load_ack;
    logic [3:0]  nibble;
    logic [1:0]  digit;
    logic [3:0]  an;
    logic        frame;

    modport master (
        output en, value, load,
        input  load_ack, nibble, digit, an, frame
    );

    modport slave (
        input  en, value, load,
        output load_ack, nibble, digit, an, frame
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode scan controller: BLANK dead-time then SHOW per slot; loads commit at frame wrap.
// All outputs registered; no backpressure. SEG_LZ_BLANK_EN enables leading-zero blanking.
module seg_scan_ctrl #(
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 16
) (
    input  logic             clk,
    input  logic             rst,
    seg_scan_ctrl_if.slave   bus
);
    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     digit_q, digit_d;
    logic [15:0]    disp_q, disp_d;
    logic [15:0]    pend_q, pend_d;
    logic           pend_vld_q, pend_vld_d;
    logic           ack_q, ack_d;
    logic           frame_q, frame_d;
    logic [3:0]     an_q, an_d;
    logic [3:0]     nibble_q, nibble_d;
    logic           commit;
    logic [3:0]     lit;

    always_comb begin
        cnt_d      = cnt_q;
        digit_d    = digit_q;
        state_d    = state_q;
        disp_d     = disp_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ack_d      = 1'b0;
        an_d       = 4'hF;
        lit        = 4'hF;

        if (!bus.en) begin
            cnt_d   = '0;
            digit_d = 2'd0;
            state_d = ST_BLANK;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            digit_d = digit_q + 2'd1;
            state_d = ST_BLANK;
        end else begin
            cnt_d = cnt_q + CW'(1);
            if (state_q == ST_BLANK && cnt_q == BLANK_LAST)
                state_d = ST_SHOW;
        end

        // Disabled scan commits every cycle; otherwise only on the 3->0 wrap.
        commit = !bus.en || (cnt_q == CNT_LAST && digit_q == 2'd3);

        if (commit) begin
            if (bus.load) begin
                disp_d     = bus.value;
                pend_vld_d = 1'b0;
                ack_d      = 1'b1;
            end else if (pend_vld_q) begin
                disp_d     = pend_q;
                pend_vld_d = 1'b0;
                ack_d      = 1'b1;
            end
        end else if (bus.load) begin
            pend_d     = bus.value;
            pend_vld_d = 1'b1;
        end

`ifdef SEG_LZ_BLANK_EN
        lit = {|disp_d[15:12], |disp_d[15:8], |disp_d[15:4], 1'b1};
`endif

        if (bus.en && state_d == ST_SHOW && lit[digit_d])
            an_d = ~(4'b0001 << digit_d);

        nibble_d = disp_d[{digit_d, 2'b00} +: 4];
        frame_d  = bus.en && (cnt_d == CNT_LAST) && (digit_d == 2'd3);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BLANK;
            cnt_q      <= '0;
            digit_q    <= 2'd0;
            disp_q     <= 16'h0;
            pend_q     <= 16'h0;
            pend_vld_q <= 1'b0;
            ack_q      <= 1'b0;
            frame_q    <= 1'b0;
            an_q       <= 4'hF;
            nibble_q   <= 4'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            digit_q    <= digit_d;
            disp_q     <= disp_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            ack_q      <= ack_d;
            frame_q    <= frame_d;
            an_q       <= an_d;
            nibble_q   <= nibble_d;
        end
    end

    assign bus.load_ack = ack_q;
    assign bus.nibble   = nibble_q;
    assign bus.digit    = digit_q;
    assign bus.an       = an_q;
    assign bus.frame    = frame_q;
endmodule
